pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Fetch/issue controller that sequences the 8-bit program counter register.
- Reads the current PC value (pc_q) and drives the PC's next-address input (pc_d) every cycle.
- Runs an instruction-memory request/acknowledge handshake and issues each fetched instruction downstream with a valid/ready handshake.
- Applies sequential increment, taken-branch redirect, asynchronous flush and halt.

Parameters:
- AW, 8, address width; must match the PC register.
- IW, 32, instruction word width.
- STEP, 4, byte increment per sequential instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr_n  in  1  reset; asynchronous, active-low.
- pc_q  in  AW  current PC register output.
- pc_d  out  AW  next-address input to the PC register; the PC loads it on every clk edge.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  AW  fetch address; always equals pc_q.
- imem_ack  in  1  fetch done; imem_rdata is valid in the same cycle.
- imem_rdata  in  IW  fetched instruction.
- instr_valid  out  1  issued instruction is valid.
- instr  out  IW  issued instruction, registered.
- instr_ready  in  1  downstream accepts the instruction.
- br_taken  in  1  taken-branch flag; sampled only on an issue handshake.
- br_target  in  AW  branch/call target address.
- flush  in  1  redirect request; overrides everything except reset.
- flush_target  in  AW  redirect address.
- halt  in  1  stop after the current issue handshake.
- call  in  1  call marker; see Optional Feature.
- ret  in  1  return marker; see Optional Feature.
- halted  out  1  high in the HALTED state.
- ras_err  out  1  one-cycle pulse on RAS underflow.

Behaviour:
- Reset: while clr_n is low, all of the following hold regardless of clk.
  - State is IDLE.
  - pc_d is 0. imem_req, instr_valid, halted and ras_err are 0.
  - instr is 0. The RAS is empty.
- FSM states: IDLE, FETCH, ISSUE, HALTED.
- IDLE:
  - pc_d is 0.
  - Unconditionally goes to FETCH on the next edge, so the first fetch is from address 0.
- FETCH:
  - imem_req is 1 and pc_d = pc_q (PC holds).
  - When imem_ack is 1: instr <= imem_rdata and the FSM goes to ISSUE.
- ISSUE:
  - instr_valid is 1 and instr is held stable.
  - While instr_ready is 0: pc_d = pc_q and the FSM stays in ISSUE.
  - When instr_ready is 1 (handshake cycle), pc_d is selected as follows:
    - br_taken = 1: br_target.
    - otherwise: (pc_q + STEP) mod 2^AW. Overflow wraps silently, e.g. 0xFC -> 0x00.
  - After the handshake, the next state is HALTED if halt is 1, otherwise FETCH.
- HALTED:
  - halted is 1, pc_d = pc_q, and no requests are made.
  - Exits only through reset. flush is ignored in this state.
- flush:
  - In IDLE, FETCH or ISSUE, flush = 1 forces pc_d = flush_target and next state FETCH.
  - It discards the pending fetch or issued instruction; instr_valid drops next cycle.
  - flush beats a same-cycle imem_ack or issue handshake, including br_taken, halt, call and ret.
- Outside FETCH, imem_ack is ignored (covers a late ack after a flush).
- Throughput: at best 2 cycles per instruction (ack in the first FETCH cycle, ready in the first ISSUE cycle).
  - The PC update is visible on pc_q in the cycle after the handshake. imem_addr follows pc_q.
- Output types:
  - pc_d, imem_req, imem_addr, instr_valid and halted are combinational from state and inputs.
  - instr and ras_err are registered.

Optional Feature:
- Macro: PC_SEQUENCER_RAS_EN.
- Defined: a 4-entry return-address stack (RAS) is active and applies only on an issue handshake without flush.
  - call = 1: push (pc_q + STEP) mod 2^AW, and pc_d = br_target.
  - A push onto a full stack overwrites the oldest entry.
  - ret = 1: pop, and pc_d = the popped value.
  - ret on an empty stack: pc_d = pc_q + STEP and ras_err pulses for 1 cycle.
  - call and ret together: treated as ret followed by call, so the popped entry is replaced by pc_q + STEP and pc_d = br_target.
  - call or ret take priority over br_taken.
- Undefined: no RAS storage. call and ret are ignored and ras_err is tied to 0.

Test Plan:
- Sequential fetch: release clr_n with imem_ack and instr_ready tied 1 -> imem_addr sequence 0x00, 0x04, 0x08, with one instruction every 2 cycles.
- Stalls: hold imem_ack low for 3 cycles, then hold instr_ready low for 2 cycles -> pc_q stays constant throughout and instr is stable while instr_valid is 1.
- Branch and wrap-around:
  - At PC 0x10, issue with br_taken = 1 and br_target = 0x40 -> next fetch address 0x40.
  - At PC 0xFC with no branch -> next fetch address 0x00.
- Flush priority:
  - flush with flush_target = 0x80 in the same cycle as imem_ack -> instr is not issued and the next fetch is 0x80.
  - A late imem_ack after the flush is ignored.
- Halt and reset mid-fetch:
  - halt = 1 on a handshake -> halted = 1 and pc_q frozen.
  - Pull clr_n low in the middle of FETCH -> imem_req drops immediately and the next fetch after release is from 0x00.
- RAS (PC_SEQUENCER_RAS_EN defined):
  - At PC 0x20, call with br_target = 0x60, then ret -> fetches 0x60, then 0x24.
  - ret with an empty stack -> ras_err = 1 for exactly 1 cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer driving the 8-bit PC: imem req/ack fetch, valid/ready issue, branch, flush, halt.
// Optional return-address stack enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
  parameter int AW   = 8,
  parameter int IW   = 32,
  parameter int STEP = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [AW-1:0] pc_q,
  output logic [AW-1:0] pc_d,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          instr_valid,
  output logic [IW-1:0] instr,
  input  logic          instr_ready,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          flush,
  input  logic [AW-1:0] flush_target,
  input  logic          halt,
  input  logic          call,
  input  logic          ret,
  output logic          halted,
  output logic          ras_err
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] pc_inc;

  assign pc_inc    = pc_q + AW'(STEP);
  assign imem_addr = pc_q;
  assign instr     = instr_q;

`ifdef PC_SEQUENCER_RAS_EN
  logic [AW-1:0] ras_q [4];
  logic [AW-1:0] ras_d [4];
  logic [1:0]    ras_sp_q, ras_sp_d, ras_sp_inc;
  logic [2:0]    ras_cnt_q, ras_cnt_d;
  logic          ras_err_q, ras_err_d;

  assign ras_sp_inc = ras_sp_q + 2'd1;
  assign ras_err    = ras_err_q;
`else
  logic unused_ras;
  assign unused_ras = ^{call, ret};
  assign ras_err    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
`ifdef PC_SEQUENCER_RAS_EN
    ras_d     = ras_q;
    ras_sp_d  = ras_sp_q;
    ras_cnt_d = ras_cnt_q;
    ras_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        pc_d    = '0;
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          pc_d    = br_taken ? br_target : pc_inc;
          state_d = halt ? HALTED : FETCH;
`ifdef PC_SEQUENCER_RAS_EN
          // call+ret acts as pop then push: a non-empty top is simply replaced
          if (ret) begin
            if (ras_cnt_q == 3'd0) begin
              ras_err_d = 1'b1;
              pc_d      = pc_inc;
            end else begin
              pc_d      = ras_q[ras_sp_q];
              ras_sp_d  = ras_sp_q - 2'd1;
              ras_cnt_d = ras_cnt_q - 3'd1;
            end
          end
          if (call) begin
            pc_d = br_target;
            if (ret && ras_cnt_q != 3'd0) begin
              ras_d[ras_sp_q] = pc_inc;
              ras_sp_d        = ras_sp_q;
              ras_cnt_d       = ras_cnt_q;
            end else begin
              ras_d[ras_sp_inc] = pc_inc;
              ras_sp_d          = ras_sp_inc;
              ras_cnt_d         = (ras_cnt_q == 3'd4) ? 3'd4 : ras_cnt_q + 3'd1;
            end
          end
`endif
        end
      end
      default: begin
        halted = 1'b1;
      end
    endcase
    // flush overrides fetch/issue outcomes, including any stack update
    if (flush && state_q != HALTED) begin
      pc_d    = flush_target;
      state_d = FETCH;
      instr_d = instr_q;
`ifdef PC_SEQUENCER_RAS_EN
      ras_d     = ras_q;
      ras_sp_d  = ras_sp_q;
      ras_cnt_d = ras_cnt_q;
      ras_err_d = 1'b0;
`endif
    end
    if (!clr_n) begin
      pc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      instr_q <= '0;
`ifdef PC_SEQUENCER_RAS_EN
      for (int i = 0; i < 4; i++) ras_q[i] <= '0;
      ras_sp_q  <= '0;
      ras_cnt_q <= '0;
      ras_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
`ifdef PC_SEQUENCER_RAS_EN
      ras_q     <= ras_d;
      ras_sp_q  <= ras_sp_d;
      ras_cnt_q <= ras_cnt_d;
      ras_err_q <= ras_err_d;
`endif
    end
  end

endmodule
